// File: rtl/wyswietlacz_n.sv
// Multiplexed 7-segment display driver: a binary value is converted to BCD by an
// iterative shift-add-3 engine and scanned one digit at a time onto E/Q.
module wyswietlacz_n #(
  parameter int DIGITS   = 4,
  parameter int WIDTH    = 14,
  parameter int SCAN_DIV = 1000
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              CE,
  input  logic [WIDTH-1:0]  IN,
  input  logic              LOAD,
  input  logic [DIGITS-1:0] DP,
  input  logic              BLANK_LZ,
  output logic              BUSY,
  output logic              OVF,
  output logic [DIGITS-1:0] E,
  output logic [7:0]        Q
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CONV = 1'b1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  // Segment patterns for Q[6:0], active low, a in bit 0.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------- conversion
  logic [0:0]       state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sh;
  logic [BW-1:0]    acc;
  logic [BW-1:0]    acc_adj;
  logic [BW-1:0]    acc_next;
  logic             ovf_pend;
  logic             ovf_in;
  logic [BW-1:0]    disp;
  logic             ovf_r;

  assign ovf_in = (64'(IN) >= LIMIT);

  // Upper digits beyond DIGITS are dropped; the lower digits stay exact since
  // corrections only carry upward, and an overflowing value shows dashes anyway.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    acc_adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
    acc_next = {acc_adj[BW-2:0], sh[WIDTH-1]};
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!CLR) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      sh       <= '0;
      acc      <= '0;
      ovf_pend <= 1'b0;
      disp     <= '0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (LOAD) begin
            sh       <= IN;
            acc      <= '0;
            bit_cnt  <= '0;
            ovf_pend <= ovf_in;
            state    <= ST_CONV;
          end
        end
        default: begin
          if (bit_cnt == CW'(WIDTH)) begin
            disp  <= acc;
            ovf_r <= ovf_pend;
            state <= ST_IDLE;
          end else begin
            acc     <= acc_next;
            sh      <= {sh[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign BUSY = (state == ST_CONV);
  assign OVF  = ovf_r;

  // ---------------------------------------------------------------- scanning
  logic [PW-1:0]     presc;
  logic [IW-1:0]     idx;
  logic [DIGITS-1:0] lz;
  logic              lz_run;
  logic [3:0]        dig_sel;
  logic              blank_sel;
  logic              dp_sel;
  logic [6:0]        seg_sel;
  logic [7:0]        q_next;

  // lz[k]: positions 0..k all hold zero digits (position 0 is most significant).
  always_comb begin
    lz_run = 1'b1;
    lz     = '0;
    for (int k = 0; k < DIGITS; k++) begin
      lz_run = lz_run & (disp[4*(DIGITS-1-k) +: 4] == 4'd0);
      lz[k]  = lz_run;
    end
  end

  always_comb begin
    dig_sel   = 4'd0;
    blank_sel = 1'b0;
    dp_sel    = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        dig_sel   = disp[4*(DIGITS-1-k) +: 4];
        blank_sel = BLANK_LZ && (k != DIGITS - 1) && lz[k];
        dp_sel    = DP[k];
      end
    end
    if (ovf_r)          seg_sel = 7'h3F;
    else if (blank_sel) seg_sel = 7'h7F;
    else                seg_sel = seg7(dig_sel);
    q_next = {~dp_sel, seg_sel};
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      presc <= '0;
      idx   <= '0;
      E     <= '1;
      Q     <= 8'hFF;
    end else if (CE) begin
      E <= ~(DIGITS'(1) << idx);
      Q <= q_next;
      if (presc == PW'(SCAN_DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wyswietlacz_n.sv
// Self-checking bench for wyswietlacz_n (DIGITS=4, WIDTH=14, SCAN_DIV=4) against a
// decimal-arithmetic reference model, with directed scenarios then random traffic.
`timescale 1ns/1ps
module tb_wyswietlacz_n;

  localparam int DIGITS   = 4;
  localparam int WIDTH    = 14;
  localparam int SCAN_DIV = 4;
  localparam int LIMIT    = 10 ** DIGITS;

  localparam logic [7:0] SEG_TBL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic              CLK = 1'b0;
  logic              CLR = 1'b0;
  logic              CE = 1'b0;
  logic [WIDTH-1:0]  IN = '0;
  logic              LOAD = 1'b0;
  logic [DIGITS-1:0] DP = '0;
  logic              BLANK_LZ = 1'b0;
  logic              BUSY;
  logic              OVF;
  logic [DIGITS-1:0] E;
  logic [7:0]        Q;

  wyswietlacz_n #(.DIGITS(DIGITS), .WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
    .CLK(CLK), .CLR(CLR), .CE(CE), .IN(IN), .LOAD(LOAD), .DP(DP),
    .BLANK_LZ(BLANK_LZ), .BUSY(BUSY), .OVF(OVF), .E(E), .Q(Q)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: a busy countdown, the committed decimal value and a count of CE edges.
  int         m_left = 0;
  int         m_pend = 0;
  int         m_val  = 0;
  bit         m_ovf  = 0;
  int         m_ce   = 0;
  logic [3:0] m_e    = 4'hF;
  logic [7:0] m_q    = 8'hFF;

  function automatic logic [7:0] exp_q(input int k, input int val, input bit ovf,
                                       input logic [3:0] dp, input bit blz);
    int pw;
    logic [7:0] lo;
    pw = 1;
    for (int i = 0; i < DIGITS - 1 - k; i++) pw = pw * 10;
    if (ovf)                                   lo = 8'hBF;
    else if (blz && k < DIGITS - 1 && val < pw) lo = 8'hFF;
    else                                       lo = SEG_TBL[(val / pw) % 10];
    return {~dp[k], lo[6:0]};
  endfunction

  task automatic tick(input bit clr, input bit ce, input bit load, input int in_v,
                      input logic [3:0] dp_v, input bit blz);
    int k;
    CLR = clr; CE = ce; LOAD = load; IN = WIDTH'(in_v); DP = dp_v; BLANK_LZ = blz;
    @(posedge CLK);
    if (!clr) begin
      m_left = 0; m_val = 0; m_ovf = 0; m_ce = 0; m_e = 4'hF; m_q = 8'hFF;
    end else begin
      if (ce) begin
        k   = (m_ce / SCAN_DIV) % DIGITS;
        m_e = ~(4'b0001 << k);
        m_q = exp_q(k, m_val, m_ovf, dp_v, blz);
        m_ce++;
      end
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_val = m_pend % LIMIT;
          m_ovf = (m_pend >= LIMIT);
        end
      end else if (load) begin
        m_pend = in_v;
        m_left = WIDTH + 1;
      end
    end
    #1;
    check("BUSY", 32'(BUSY), 32'(m_left > 0));
    check("OVF",  32'(OVF),  32'(m_ovf));
    check("E",    32'(E),    32'(m_e));
    check("Q",    32'(Q),    32'(m_q));
  endtask

  task automatic run(input int n, input bit ce, input logic [3:0] dp_v, input bit blz);
    for (int i = 0; i < n; i++) tick(1'b1, ce, 1'b0, 0, dp_v, blz);
  endtask

  task automatic load(input int v, input bit blz);
    tick(1'b1, 1'b1, 1'b1, v, 4'b0000, blz);
  endtask

  initial begin
    // Reset, then idle scan of value 0 with blanking.
    tick(1'b0, 1'b1, 1'b1, 1234, 4'b0000, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 0, 4'b0000, 1'b1);
    run(20, 1'b1, 4'b0000, 1'b1);

    // 1234 shown across all four positions.
    load(1234, 1'b1);
    run(40, 1'b1, 4'b0000, 1'b1);

    // Leading-zero blanking on and off.
    load(7, 1'b1);
    run(32, 1'b1, 4'b0000, 1'b1);
    run(16, 1'b1, 4'b0000, 1'b0);

    // Overflow boundary.
    load(10000, 1'b1);
    run(32, 1'b1, 4'b0000, 1'b1);
    load(9999, 1'b1);
    run(32, 1'b1, 4'b0000, 1'b1);

    // Second LOAD during conversion is ignored.
    load(5, 1'b1);
    run(2, 1'b1, 4'b0000, 1'b1);
    load(9, 1'b1);
    run(30, 1'b1, 4'b0000, 1'b1);

    // Reset at cycle 5 of a conversion aborts it.
    load(123, 1'b1);
    run(4, 1'b1, 4'b0000, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 0, 4'b0000, 1'b1);
    run(24, 1'b1, 4'b0000, 1'b1);

    // LOAD in the commit cycle ignored, LOAD in the next cycle accepted.
    load(42, 1'b1);
    run(WIDTH, 1'b1, 4'b0000, 1'b1);
    load(77, 1'b1);
    load(88, 1'b1);
    run(30, 1'b1, 4'b0000, 1'b1);

    // CE held low mid-position, then decimal point on position 2.
    run(2, 1'b1, 4'b0000, 1'b0);
    run(10, 1'b0, 4'b0000, 1'b0);
    run(20, 1'b1, 4'b0100, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int v;
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(9990, 10010);
        default: v = $urandom_range(0, (1 << WIDTH) - 1);
      endcase
      tick(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), v, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
